// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle sequencer for DIV / DIVU / REM / REMU.
//   Radix-2 restoring division, one quotient bit per clock (XLEN iterations),
//   followed by a sign-fix cycle. Divide-by-zero, signed overflow and hits in
//   a one-entry quotient/remainder cache complete in a single cycle.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   Start             request, sampled only while Ready
//   Div_Op[1:0]       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Src1, Src2        dividend, divisor
//   Flush             abort current op, return to IDLE
//   Ready             high in IDLE
//   Busy              high in CALC and FIX
//   Done              one-cycle pulse, Result valid
//   Result            quotient or remainder, held until the next Done
module div_seq_ctrl #(
  parameter int XLEN     = 32,
  parameter int CACHE_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [1:0]      Div_Op,
  input  logic [XLEN-1:0] Src1,
  input  logic [XLEN-1:0] Src2,
  input  logic            Flush,
  output logic            Ready,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t r_state, w_nxt;

  // latched request
  logic            r_is_rem;
  logic            r_sgn;
  logic [XLEN-1:0] r_a, r_b;
  // iterative datapath
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo, r_div;
  logic            r_neg_q, r_neg_r;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;
  // last-result cache
  logic            r_c_vld, r_c_sgn;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_quo, r_c_rem;

  logic            w_sgn, w_is_rem, w_accept;
  logic            w_dz, w_ovf, w_hit, w_special;
  logic [XLEN-1:0] w_spec_res, w_a_mag, w_b_mag;
  logic [XLEN:0]   w_rem_sh, w_rem_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_quo_fin, w_rem_fin;

  assign w_sgn    = ~Div_Op[0];
  assign w_is_rem = Div_Op[1];
  assign w_accept = (r_state == S_IDLE) && Start && !Flush;

  assign w_dz  = (Src2 == '0);
  assign w_ovf = w_sgn && (Src1 == {1'b1, {(XLEN-1){1'b0}}}) && (Src2 == '1);
  assign w_hit = (CACHE_EN != 0) && r_c_vld && (Src1 == r_c_a) &&
                 (Src2 == r_c_b) && (w_sgn == r_c_sgn);
  assign w_special = w_dz || w_ovf || w_hit;

  always_comb begin
    w_spec_res = '0;
    if (w_dz)       w_spec_res = w_is_rem ? Src1 : '1;
    else if (w_ovf) w_spec_res = w_is_rem ? '0 : Src1;
    else if (w_hit) w_spec_res = w_is_rem ? r_c_rem : r_c_quo;
  end

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  assign w_a_mag = (w_sgn && Src1[XLEN-1]) ? -Src1 : Src1;
  assign w_b_mag = (w_sgn && Src2[XLEN-1]) ? -Src2 : Src2;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  assign w_rem_sh  = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_div};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});

  assign w_quo_fin = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fin = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    Ready = 1'b0;
    Busy  = 1'b0;
    Done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        Ready = 1'b1;
        if (w_accept) w_nxt = w_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        Busy = 1'b1;
        if (r_cnt == LAST) w_nxt = S_FIX;
      end
      S_FIX: begin
        Busy  = 1'b1;
        w_nxt = S_DONE;
      end
      S_DONE: begin
        Done  = 1'b1;
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (Flush) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_rem <= 1'b0;
      r_sgn    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_c_vld  <= 1'b0;
      r_c_sgn  <= 1'b0;
      r_c_a    <= '0;
      r_c_b    <= '0;
      r_c_quo  <= '0;
      r_c_rem  <= '0;
    end else begin
      if (w_accept) begin
        r_is_rem <= w_is_rem;
        r_sgn    <= w_sgn;
        r_a      <= Src1;
        r_b      <= Src2;
        r_rem    <= '0;
        r_quo    <= w_a_mag;
        r_div    <= w_b_mag;
        r_neg_q  <= w_sgn && (Src1[XLEN-1] ^ Src2[XLEN-1]);
        r_neg_r  <= w_sgn && Src1[XLEN-1];
        r_cnt    <= '0;
        if (w_special) r_result <= w_spec_res;
      end
      if (r_state == S_CALC && !Flush) begin
        r_rem <= w_ge ? w_rem_sub : w_rem_sh;
        r_quo <= {r_quo[XLEN-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_FIX && !Flush) begin
        r_result <= r_is_rem ? w_rem_fin : w_quo_fin;
        r_c_vld  <= 1'b1;
        r_c_sgn  <= r_sgn;
        r_c_a    <= r_a;
        r_c_b    <= r_b;
        r_c_quo  <= w_quo_fin;
        r_c_rem  <= w_rem_fin;
      end
      // An abort mid-computation drops the cache so a stale pair can't hit.
      if (Flush && (r_state == S_CALC || r_state == S_FIX)) r_c_vld <= 1'b0;
    end
  end

  assign Result = r_result;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            Start = 1'b0;
  logic [1:0]      Div_Op = 2'b00;
  logic [XLEN-1:0] Src1 = '0, Src2 = '0;
  logic            Flush = 1'b0;
  logic            Ready, Busy, Done;
  logic [XLEN-1:0] Result;

  int total = 0;
  int bad = 0;
  logic [XLEN-1:0] sb_q[$];

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_seq_ctrl #(.XLEN(XLEN), .CACHE_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Div_Op(Div_Op), .Src1(Src1),
    .Src2(Src2), .Flush(Flush), .Ready(Ready), .Busy(Busy), .Done(Done),
    .Result(Result)
  );

  always #5 clk = ~clk;

  // RISC-V M reference
  function automatic logic [XLEN-1:0] ref_div(input logic [1:0] op,
                                              input logic [XLEN-1:0] a, b);
    logic signed [XLEN-1:0] sa, sb, sq, sr;
    logic [XLEN-1:0] q, r;
    sa = a; sb = b;
    if (b == '0) begin
      q = '1; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == '1) begin
      q = a; r = '0;
    end else if (!op[0]) begin
      sq = sa / sb; sr = sa % sb; q = sq; r = sr;
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one request for a single cycle; returns at E0 + 1ns.
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, b);
    Div_Op = op; Src1 = a; Src2 = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    Src1 = $urandom; Src2 = $urandom; Div_Op = 2'($urandom);
  endtask

  // Waits for Done; lat = edges after E0, busy = cycles Busy seen.
  task automatic wait_done(output int lat, output int busy, output logic [XLEN-1:0] res,
                           output bit tmo);
    lat = 0; busy = 0; tmo = 1'b0;
    while (!Done && lat < 100) begin
      if (Busy) busy++;
      tick();
      lat++;
    end
    tmo = !Done;
    res = Result;
    tick();
  endtask

  // Pushes the expected value, runs the op, pops the expectation on Done.
  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, b,
                        output int lat, output int busy,
                        output logic [XLEN-1:0] res, output logic [XLEN-1:0] exp);
    bit tmo;
    sb_q.push_back(ref_div(op, a, b));
    issue(op, a, b);
    wait_done(lat, busy, res, tmo);
    exp = sb_q.pop_front();
    if (tmo) begin
      total++; bad++;
      $display("FAIL timeout op=%0d a=%h b=%h: no Done within 100 cycles", op, a, b);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({Ready, Busy, Done} !== 3'b100 || Result !== '0) begin
      bad++;
      $display("FAIL reset_state: rdy/busy/done=%b result=%h, want 100 / 0",
               {Ready, Busy, Done}, Result);
    end
  endtask

  task automatic test_unsigned_cache();
    int lat, busy; logic [XLEN-1:0] res, exp;
    run_op(OP_DIVU, 100, 7, lat, busy, res, exp);
    total++;
    if (res !== exp || exp !== 32'd14) begin bad++; $display("FAIL divu_100_7: got %h want %h", res, exp); end
    total++;
    if (lat !== 33 || busy !== 33) begin bad++; $display("FAIL divu_latency: lat=%0d busy=%0d want 33/33", lat, busy); end
    run_op(OP_REMU, 100, 7, lat, busy, res, exp);
    total++;
    if (res !== exp || lat !== 0) begin bad++; $display("FAIL remu_hit: got %h lat=%0d want %h lat=0", res, lat, exp); end
  endtask

  task automatic test_signed();
    int lat, busy; logic [XLEN-1:0] res, exp;
    run_op(OP_DIV, 32'hFFFF_FFF9, 2, lat, busy, res, exp);
    total++;
    if (res !== 32'hFFFF_FFFD || lat !== 33) begin bad++; $display("FAIL div_m7_2: got %h lat=%0d want fffffffd lat=33", res, lat); end
    run_op(OP_REM, 32'hFFFF_FFF9, 2, lat, busy, res, exp);
    total++;
    if (res !== 32'hFFFF_FFFF || lat !== 0) begin bad++; $display("FAIL rem_m7_2_hit: got %h lat=%0d want ffffffff lat=0", res, lat); end
  endtask

  task automatic test_special();
    int lat, busy; logic [XLEN-1:0] res, exp;
    logic [1:0]      ops[4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [XLEN-1:0] as[4]  = '{32'h8000_0000, 32'h8000_0000, 5, 5};
    logic [XLEN-1:0] bs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
    logic [XLEN-1:0] ws[4]  = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd5};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, busy, res, exp);
      total++;
      if (res !== ws[i] || res !== exp || lat !== 0 || busy !== 0) begin
        bad++;
        $display("FAIL special_%0d: got %h lat=%0d busy=%0d want %h lat=0", i, res, lat, busy, ws[i]);
      end
    end
    // signed divide by zero
    run_op(OP_REM, 32'hFFFF_FF00, 0, lat, busy, res, exp);
    total++;
    if (res !== 32'hFFFF_FF00 || lat !== 0) begin bad++; $display("FAIL rem_by_zero: got %h want ffffff00", res); end
  endtask

  task automatic test_flush();
    int lat, busy; logic [XLEN-1:0] res, exp, held;
    bit seen;
    run_op(OP_DIVU, 1000, 3, lat, busy, res, exp);   // fills cache with 1000/3
    held = Result;
    issue(OP_DIVU, 7, 2);
    repeat (9) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    total++;
    if ({Ready, Busy, Done} !== 3'b100 || Result !== held) begin
      bad++;
      $display("FAIL flush_idle: rdy/busy/done=%b result=%h want 100 / %h", {Ready, Busy, Done}, Result, held);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin if (Done) seen = 1'b1; tick(); end
    total++;
    if (seen) begin bad++; $display("FAIL flush_no_done: Done pulsed after flush"); end
    run_op(OP_REMU, 1000, 3, lat, busy, res, exp);
    total++;
    if (res !== 32'd1 || lat !== 33) begin bad++; $display("FAIL flush_cache_inval: got %h lat=%0d want 1 lat=33", res, lat); end
    // Flush and Start together in IDLE
    Flush = 1'b1;
    issue(OP_DIVU, 9, 3);
    Flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin if (Done || !Ready) seen = 1'b1; tick(); end
    total++;
    if (seen) begin bad++; $display("FAIL flush_start_same: op accepted despite Flush"); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    issue(OP_DIVU, 12345, 11);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({Ready, Busy, Done} !== 3'b100 || Result !== '0) begin
      bad++;
      $display("FAIL reset_mid: rdy/busy/done=%b result=%h want 100 / 0", {Ready, Busy, Done}, Result);
    end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin if (Done) seen = 1'b1; tick(); end
    total++;
    if (seen) begin bad++; $display("FAIL reset_mid_no_done: Done after reset"); end
  endtask

  task automatic test_back_to_back();
    int lat, busy; logic [XLEN-1:0] res, exp;
    bit seen, tmo;
    // Start while busy is ignored
    sb_q.push_back(ref_div(OP_DIVU, 100, 7));
    issue(OP_DIVU, 100, 7);
    repeat (4) tick();
    issue(OP_DIV, 50, 5);
    wait_done(lat, busy, res, tmo);
    exp = sb_q.pop_front();
    total++;
    if (tmo || res !== exp || lat !== 38 - 5 + 0 - 0 + 0 && 0) begin end
    if (tmo || res !== exp || res !== 32'd14) begin bad++; $display("FAIL start_while_busy: got %h want %h", res, exp); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin if (Done) seen = 1'b1; tick(); end
    total++;
    if (seen) begin bad++; $display("FAIL start_while_busy_queued: extra Done"); end
    // signedness mismatch must miss the cache
    run_op(OP_DIVU, 32'hFFFF_FFF9, 2, lat, busy, res, exp);
    total++;
    if (res !== 32'h7FFF_FFFC || lat !== 33) begin bad++; $display("FAIL divu_fff9: got %h lat=%0d want 7ffffffc lat=33", res, lat); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 2, lat, busy, res, exp);
    total++;
    if (res !== 32'hFFFF_FFFD || lat !== 33) begin bad++; $display("FAIL sign_miss: got %h lat=%0d want fffffffd lat=33", res, lat); end
  endtask

  task automatic test_random();
    int lat, busy; logic [XLEN-1:0] res, exp, a, b;
    logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(3))
        0: b = $urandom_range(15);
        1: b = -$urandom_range(15);
        default: b = $urandom >> $urandom_range(31);
      endcase
      run_op(op, a, b, lat, busy, res, exp);
      total++;
      if (res !== exp) begin bad++; $display("FAIL random_%0d: op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, exp); end
    end
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_unsigned_cache();
    test_signed();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
